// File: rtl/bf16_issue_queue.sv
// rtl/bf16_issue_queue.sv - command FIFO and in-order sequencer in front of BF16Unit
// Buffers commands, issues them under an in-flight limit and tags results with their opcode.
module bf16_issue_queue #(
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 2,
  parameter int DATA_W       = 16,
  parameter int OPC_W        = 3
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            io_enq_valid,
  output logic                            io_enq_ready,
  input  logic [OPC_W-1:0]                io_enq_opc,
  input  logic [DATA_W-1:0]               io_enq_a,
  input  logic [DATA_W-1:0]               io_enq_b,
  input  logic                            io_enq_isSqrt,
  input  logic                            io_flush,
  output logic                            io_fu_valid,
  input  logic                            io_fu_ready,
  output logic [OPC_W-1:0]                io_fu_opc,
  output logic [DATA_W-1:0]               io_fu_a,
  output logic [DATA_W-1:0]               io_fu_b,
  output logic                            io_fu_isSqrt,
  output logic                            io_fu_kill,
  input  logic                            io_fu_out_valid,
  output logic                            io_fu_out_ready,
  input  logic [DATA_W-1:0]               io_fu_y,
  output logic                            io_res_valid,
  input  logic                            io_res_ready,
  output logic [DATA_W-1:0]               io_res_y,
  output logic [OPC_W-1:0]                io_res_opc,
  output logic [$clog2(DEPTH):0]          io_count,
  output logic [$clog2(MAX_INFLIGHT):0]   io_inflight,
  output logic                            io_err
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int TPW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int IW  = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [CW-1:0]  DEPTH_C   = CW'(DEPTH);
  localparam logic [IW-1:0]  MAXI_C    = IW'(MAX_INFLIGHT);
  localparam logic [PW-1:0]  PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [TPW-1:0] TPTR_LAST = TPW'(MAX_INFLIGHT - 1);

  typedef enum logic {ST_RUN = 1'b0, ST_KILL = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [OPC_W-1:0]   opc_mem_q  [DEPTH];
  logic [DATA_W-1:0]  a_mem_q    [DEPTH];
  logic [DATA_W-1:0]  b_mem_q    [DEPTH];
  logic               sqrt_mem_q [DEPTH];
  logic [OPC_W-1:0]   tag_mem_q  [MAX_INFLIGHT];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [TPW-1:0]     tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CW-1:0]      count_q, count_d;
  logic [IW-1:0]      inflight_q, inflight_d;
  logic               err_q, err_d;
  logic               run, enq_fire, iss_fire, res_fire;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [TPW-1:0] inc_tptr(input logic [TPW-1:0] p);
    return (p == TPTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // KILL lasts exactly one cycle; a flush arriving during KILL is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (io_flush) state_d = ST_KILL;
      ST_KILL: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    run             = (state_q == ST_RUN);
    io_fu_kill      = !run;
    io_enq_ready    = run && (count_q < DEPTH_C);
    io_fu_valid     = run && (count_q != '0) && (inflight_q < MAXI_C);
    io_fu_opc       = opc_mem_q[rd_ptr_q];
    io_fu_a         = a_mem_q[rd_ptr_q];
    io_fu_b         = b_mem_q[rd_ptr_q];
    io_fu_isSqrt    = sqrt_mem_q[rd_ptr_q];
    io_res_valid    = run && io_fu_out_valid && (inflight_q != '0);
    io_fu_out_ready = (run && (inflight_q != '0)) ? io_res_ready : 1'b1;
    io_res_y        = io_fu_y;
    io_res_opc      = tag_mem_q[tag_rd_q];
    io_count        = count_q;
    io_inflight     = inflight_q;
    io_err          = err_q;
  end

  assign enq_fire = io_enq_valid && io_enq_ready;
  assign iss_fire = io_fu_valid && io_fu_ready;
  assign res_fire = io_res_valid && io_res_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    err_d      = err_q;
    if (!run) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      tag_wr_d   = '0;
      tag_rd_d   = '0;
      count_d    = '0;
      inflight_d = '0;
    end else begin
      if (enq_fire) wr_ptr_d = inc_ptr(wr_ptr_q);
      if (iss_fire) begin
        rd_ptr_d = inc_ptr(rd_ptr_q);
        tag_wr_d = inc_tptr(tag_wr_q);
      end
      if (res_fire) tag_rd_d = inc_tptr(tag_rd_q);
      case ({enq_fire, iss_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      case ({iss_fire, res_fire})
        2'b10:   inflight_d = inflight_q + 1'b1;
        2'b01:   inflight_d = inflight_q - 1'b1;
        default: inflight_d = inflight_q;
      endcase
      // A result with nothing outstanding is an orphan: drop it, remember it.
      if (io_fu_out_valid && (inflight_q == '0)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        opc_mem_q[i]  <= '0;
        a_mem_q[i]    <= '0;
        b_mem_q[i]    <= '0;
        sqrt_mem_q[i] <= 1'b0;
      end
      for (int i = 0; i < MAX_INFLIGHT; i++) tag_mem_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
      if (enq_fire) begin
        opc_mem_q[wr_ptr_q]  <= io_enq_opc;
        a_mem_q[wr_ptr_q]    <= io_enq_a;
        b_mem_q[wr_ptr_q]    <= io_enq_b;
        sqrt_mem_q[wr_ptr_q] <= io_enq_isSqrt;
      end
      if (iss_fire) tag_mem_q[tag_wr_q] <= io_fu_opc;
    end
  end

endmodule

// File: tb/tb_bf16_issue_queue.sv
// tb/tb_bf16_issue_queue.sv - self-checking bench for bf16_issue_queue
// Vector table, queue-based random reference model, and flush/err/reset sequences.
module tb_bf16_issue_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_enq_valid, io_enq_ready, io_enq_isSqrt, io_flush;
  logic [2:0]  io_enq_opc, io_fu_opc, io_res_opc;
  logic [15:0] io_enq_a, io_enq_b, io_fu_a, io_fu_b, io_fu_y, io_res_y;
  logic        io_fu_valid, io_fu_ready, io_fu_isSqrt, io_fu_kill;
  logic        io_fu_out_valid, io_fu_out_ready, io_res_valid, io_res_ready, io_err;
  logic [2:0]  io_count;
  logic [1:0]  io_inflight;

  int checks = 0;
  int errors = 0;

  bf16_issue_queue dut (
    .clock(clock), .reset(reset),
    .io_enq_valid(io_enq_valid), .io_enq_ready(io_enq_ready), .io_enq_opc(io_enq_opc),
    .io_enq_a(io_enq_a), .io_enq_b(io_enq_b), .io_enq_isSqrt(io_enq_isSqrt), .io_flush(io_flush),
    .io_fu_valid(io_fu_valid), .io_fu_ready(io_fu_ready), .io_fu_opc(io_fu_opc),
    .io_fu_a(io_fu_a), .io_fu_b(io_fu_b), .io_fu_isSqrt(io_fu_isSqrt), .io_fu_kill(io_fu_kill),
    .io_fu_out_valid(io_fu_out_valid), .io_fu_out_ready(io_fu_out_ready), .io_fu_y(io_fu_y),
    .io_res_valid(io_res_valid), .io_res_ready(io_res_ready), .io_res_y(io_res_y),
    .io_res_opc(io_res_opc), .io_count(io_count), .io_inflight(io_inflight), .io_err(io_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic ev; logic [2:0] opc; logic [15:0] a; logic fr; logic ov; logic [15:0] y; logic rr;
    logic x_er; logic x_fv; logic [2:0] x_fopc; logic [15:0] x_fa;
    logic x_rv; logic [15:0] x_ry; logic [2:0] x_ropc; logic x_for; int x_cnt; int x_inf;
  } vec_t;

  typedef struct { logic [2:0] opc; logic [15:0] a; logic [15:0] b; logic sq; } cmd_t;

  vec_t tv [22];
  cmd_t mq [$];
  logic [2:0]  tq [$];
  logic [15:0] pq [$];

  function automatic vec_t mkv(input logic ev, input logic [2:0] opc, input logic [15:0] a,
      input logic fr, input logic ov, input logic [15:0] y, input logic rr,
      input logic xer, input logic xfv, input logic [2:0] xfo, input logic [15:0] xfa,
      input logic xrv, input logic [15:0] xry, input logic [2:0] xro, input logic xfor,
      input int xc, input int xi);
    vec_t v;
    v.ev = ev; v.opc = opc; v.a = a; v.fr = fr; v.ov = ov; v.y = y; v.rr = rr;
    v.x_er = xer; v.x_fv = xfv; v.x_fopc = xfo; v.x_fa = xfa;
    v.x_rv = xrv; v.x_ry = xry; v.x_ropc = xro; v.x_for = xfor; v.x_cnt = xc; v.x_inf = xi;
    return v;
  endfunction

  function automatic logic [15:0] fu_model(input cmd_t c);
    return c.a ^ {c.b[7:0], c.b[15:8]} ^ {15'd0, c.sq};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    io_enq_valid = 0; io_enq_opc = 0; io_enq_a = 0; io_enq_b = 0; io_enq_isSqrt = 0;
    io_flush = 0; io_fu_ready = 1; io_fu_out_valid = 0; io_fu_y = 0; io_res_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 0;
    mq.delete(); tq.delete(); pq.delete();
  endtask

  initial begin
    cmd_t c;
    logic xer, xfv, xrv, fe, fi, fres;

    tv[0]  = mkv(1,0,16'h41cc,1,0,16'h0000,1, 1,0,0,16'h0000, 0,16'h0000,0, 1,0,0);
    tv[1]  = mkv(0,0,16'h0000,1,0,16'h0000,1, 1,1,0,16'h41cc, 0,16'h0000,0, 1,1,0);
    tv[2]  = mkv(0,0,16'h0000,1,1,16'h423c,1, 1,0,0,16'h0000, 1,16'h423c,0, 1,0,1);
    tv[3]  = mkv(0,0,16'h0000,1,0,16'h0000,1, 1,0,0,16'h0000, 0,16'h0000,0, 1,0,0);
    tv[4]  = mkv(1,0,16'h0100,0,0,16'h0000,1, 1,0,0,16'h0000, 0,16'h0000,0, 1,0,0);
    tv[5]  = mkv(1,1,16'h0101,0,0,16'h0000,1, 1,1,0,16'h0100, 0,16'h0000,0, 1,1,0);
    tv[6]  = mkv(1,2,16'h0102,0,0,16'h0000,1, 1,1,0,16'h0100, 0,16'h0000,0, 1,2,0);
    tv[7]  = mkv(1,3,16'h0103,0,0,16'h0000,1, 1,1,0,16'h0100, 0,16'h0000,0, 1,3,0);
    tv[8]  = mkv(1,4,16'h0104,0,0,16'h0000,1, 0,1,0,16'h0100, 0,16'h0000,0, 1,4,0);
    tv[9]  = mkv(1,4,16'h0104,1,0,16'h0000,1, 0,1,0,16'h0100, 0,16'h0000,0, 1,4,0);
    tv[10] = mkv(0,0,16'h0000,1,0,16'h0000,1, 1,1,1,16'h0101, 0,16'h0000,0, 1,3,1);
    tv[11] = mkv(0,0,16'h0000,1,1,16'h423c,1, 1,0,0,16'h0000, 1,16'h423c,0, 1,2,2);
    tv[12] = mkv(0,0,16'h0000,1,1,16'h4080,1, 1,1,2,16'h0102, 1,16'h4080,1, 1,2,1);
    tv[13] = mkv(0,0,16'h0000,1,1,16'h4409,1, 1,1,3,16'h0103, 1,16'h4409,2, 1,1,1);
    tv[14] = mkv(0,0,16'h0000,1,1,16'h4409,1, 1,0,0,16'h0000, 1,16'h4409,3, 1,0,1);
    tv[15] = mkv(0,0,16'h0000,1,0,16'h0000,1, 1,0,0,16'h0000, 0,16'h0000,0, 1,0,0);
    tv[16] = mkv(1,5,16'h1234,1,0,16'h0000,1, 1,0,0,16'h0000, 0,16'h0000,0, 1,0,0);
    tv[17] = mkv(0,0,16'h0000,1,0,16'h0000,1, 1,1,5,16'h1234, 0,16'h0000,0, 1,1,0);
    tv[18] = mkv(0,0,16'h0000,1,1,16'habcd,0, 1,0,0,16'h0000, 1,16'habcd,5, 0,0,1);
    tv[19] = mkv(0,0,16'h0000,1,1,16'habcd,0, 1,0,0,16'h0000, 1,16'habcd,5, 0,0,1);
    tv[20] = mkv(0,0,16'h0000,1,1,16'habcd,1, 1,0,0,16'h0000, 1,16'habcd,5, 1,0,1);
    tv[21] = mkv(0,0,16'h0000,1,0,16'h0000,1, 1,0,0,16'h0000, 0,16'h0000,0, 1,0,0);

    // Reset state
    reset = 1;
    idle_inputs();
    #2;
    chk("rst_fu_valid", io_fu_valid, 0);
    chk("rst_res_valid", io_res_valid, 0);
    chk("rst_kill", io_fu_kill, 0);
    chk("rst_count", io_count, 0);
    chk("rst_inflight", io_inflight, 0);
    chk("rst_err", io_err, 0);
    chk("rst_fu_a", io_fu_a, 0);
    do_reset();

    // Vector table
    for (int i = 0; i < 22; i++) begin
      io_enq_valid = tv[i].ev; io_enq_opc = tv[i].opc; io_enq_a = tv[i].a;
      io_enq_b = 16'h41ac; io_enq_isSqrt = tv[i].opc[0];
      io_fu_ready = tv[i].fr; io_fu_out_valid = tv[i].ov; io_fu_y = tv[i].y;
      io_res_ready = tv[i].rr; io_flush = 0;
      #1;
      chk($sformatf("v%0d_enq_ready", i), io_enq_ready, tv[i].x_er);
      chk($sformatf("v%0d_fu_valid", i), io_fu_valid, tv[i].x_fv);
      if (tv[i].x_fv) begin
        chk($sformatf("v%0d_fu_opc", i), io_fu_opc, tv[i].x_fopc);
        chk($sformatf("v%0d_fu_a", i), io_fu_a, tv[i].x_fa);
        chk($sformatf("v%0d_fu_b", i), io_fu_b, 16'h41ac);
      end
      chk($sformatf("v%0d_res_valid", i), io_res_valid, tv[i].x_rv);
      if (tv[i].x_rv) begin
        chk($sformatf("v%0d_res_y", i), io_res_y, tv[i].x_ry);
        chk($sformatf("v%0d_res_opc", i), io_res_opc, tv[i].x_ropc);
      end
      chk($sformatf("v%0d_fu_out_ready", i), io_fu_out_ready, tv[i].x_for);
      chk($sformatf("v%0d_count", i), io_count, tv[i].x_cnt);
      chk($sformatf("v%0d_inflight", i), io_inflight, tv[i].x_inf);
      tick();
    end

    // Randomized traffic against a queue-level model
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      io_enq_valid = 1'($urandom_range(0, 1));
      io_enq_opc = 3'($urandom); io_enq_a = 16'($urandom); io_enq_b = 16'($urandom);
      io_enq_isSqrt = 1'($urandom);
      io_fu_ready = ($urandom_range(0, 3) != 0);
      io_res_ready = ($urandom_range(0, 3) != 0);
      io_fu_out_valid = (pq.size() > 0) && ($urandom_range(0, 2) != 0);
      io_fu_y = io_fu_out_valid ? pq[0] : 16'($urandom);
      #1;
      xer = (mq.size() < 4);
      xfv = (mq.size() > 0) && (tq.size() < 2);
      xrv = io_fu_out_valid && (tq.size() > 0);
      chk($sformatf("r%0d_enq_ready", cyc), io_enq_ready, xer);
      chk($sformatf("r%0d_fu_valid", cyc), io_fu_valid, xfv);
      if (xfv) begin
        chk($sformatf("r%0d_fu_head", cyc), {io_fu_opc, io_fu_a, io_fu_isSqrt},
            {mq[0].opc, mq[0].a, mq[0].sq});
        chk($sformatf("r%0d_fu_b", cyc), io_fu_b, mq[0].b);
      end
      chk($sformatf("r%0d_res_valid", cyc), io_res_valid, xrv);
      if (xrv) begin
        chk($sformatf("r%0d_res_y", cyc), io_res_y, pq[0]);
        chk($sformatf("r%0d_res_opc", cyc), io_res_opc, tq[0]);
      end
      chk($sformatf("r%0d_count", cyc), io_count, mq.size());
      chk($sformatf("r%0d_inflight", cyc), io_inflight, tq.size());
      fe = io_enq_valid && xer;
      fi = xfv && io_fu_ready;
      fres = xrv && io_res_ready;
      if (fres) begin
        void'(tq.pop_front());
        void'(pq.pop_front());
      end
      if (fi) begin
        c = mq.pop_front();
        tq.push_back(c.opc);
        pq.push_back(fu_model(c));
      end
      if (fe) begin
        c.opc = io_enq_opc; c.a = io_enq_a; c.b = io_enq_b; c.sq = io_enq_isSqrt;
        mq.push_back(c);
      end
      tick();
    end
    chk("rand_no_err", io_err, 0);

    // Flush with 3 queued and 2 in flight
    do_reset();
    for (int k = 0; k < 5; k++) begin
      io_enq_valid = 1; io_enq_opc = 3'(k + 1); io_enq_a = 16'(16'h1111 * (k + 1));
      tick();
    end
    io_enq_valid = 0;
    #1;
    chk("fl_pre_count", io_count, 3);
    chk("fl_pre_inflight", io_inflight, 2);
    io_flush = 1; io_enq_valid = 1; io_enq_opc = 7;
    #1;
    chk("fl_run_enq_ready", io_enq_ready, 1);
    chk("fl_run_kill", io_fu_kill, 0);
    tick();
    io_fu_out_valid = 1; io_fu_y = 16'h5555;
    #1;
    chk("fl_kill", io_fu_kill, 1);
    chk("fl_kill_enq_ready", io_enq_ready, 0);
    chk("fl_kill_fu_valid", io_fu_valid, 0);
    chk("fl_kill_res_valid", io_res_valid, 0);
    chk("fl_kill_out_ready", io_fu_out_ready, 1);
    tick();
    idle_inputs();
    #1;
    chk("fl_post_kill", io_fu_kill, 0);
    chk("fl_post_count", io_count, 0);
    chk("fl_post_inflight", io_inflight, 0);
    chk("fl_post_err", io_err, 0);
    io_enq_valid = 1; io_enq_opc = 6; io_enq_a = 16'h6666;
    tick();
    io_enq_valid = 0;
    #1;
    chk("fl_new_fu_valid", io_fu_valid, 1);
    chk("fl_new_fu_a", io_fu_a, 16'h6666);
    tick();
    io_fu_out_valid = 1; io_fu_y = 16'hbeef;
    #1;
    chk("fl_new_res_valid", io_res_valid, 1);
    chk("fl_new_res_opc", io_res_opc, 6);
    tick();
    io_fu_out_valid = 0;
    #1;
    chk("fl_new_inflight", io_inflight, 0);

    // Orphan result sets sticky err
    io_fu_out_valid = 1; io_fu_y = 16'h1234;
    #1;
    chk("err_res_valid", io_res_valid, 0);
    chk("err_out_ready", io_fu_out_ready, 1);
    chk("err_before", io_err, 0);
    tick();
    io_fu_out_valid = 0;
    #1;
    chk("err_set", io_err, 1);
    tick();
    tick();
    chk("err_sticky", io_err, 1);

    // Asynchronous reset in the middle of a cycle
    io_enq_valid = 1; io_enq_opc = 7; io_enq_a = 16'h7777;
    tick();
    io_enq_valid = 1; io_enq_opc = 3; io_enq_a = 16'h3333; io_fu_ready = 0;
    tick();
    io_enq_valid = 0; io_fu_out_valid = 1; io_res_ready = 0;
    #1;
    chk("ar_pre_count", io_count, 2);
    #2;
    reset = 1;
    #1;
    chk("ar_count", io_count, 0);
    chk("ar_inflight", io_inflight, 0);
    chk("ar_err", io_err, 0);
    chk("ar_fu_valid", io_fu_valid, 0);
    chk("ar_res_valid", io_res_valid, 0);
    chk("ar_kill", io_fu_kill, 0);
    chk("ar_fu_a", io_fu_a, 0);
    chk("ar_res_opc", io_res_opc, 0);
    @(negedge clock);
    reset = 0;
    idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
